// File: rtl/mem_wb_stage_unit.sv
// MEM/WB stage: captures one EX result per handshake, waits on the D-cache,
// aligns sub-word loads and holds the write-back result until it is taken.
module mem_wb_stage_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_is_mem_access,
    input  logic                      i_mem_write,
    input  logic [1:0]                i_size,
    input  logic                      i_sign_ext,
    input  logic [DATA_WIDTH-1:0]     i_alu_result,
    input  logic                      i_uses_rw,
    input  logic [REG_ADDR_WIDTH-1:0] i_rw_addr,
    input  logic                      i_cache_valid,
    input  logic [DATA_WIDTH-1:0]     i_cache_data,
    output logic                      o_wb_valid,
    input  logic                      i_wb_ready,
    output logic                      o_wb_uses_rw,
    output logic [REG_ADDR_WIDTH-1:0] o_wb_rw_addr,
    output logic [DATA_WIDTH-1:0]     o_wb_rw_data,
    output logic                      o_wb_exc,
    output logic                      o_done,
    output logic                      o_timeout
);

    localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LANE_WIDTH = $clog2(DATA_WIDTH / 8);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t                    state_q, state_n;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_n;

    logic                      req_write_q;
    logic [1:0]                req_size_q;
    logic                      req_sext_q;
    logic [DATA_WIDTH-1:0]     req_alu_q;
    logic                      req_uses_q;
    logic [REG_ADDR_WIDTH-1:0] req_addr_q;
    logic                      req_ld;

    logic                      valid_q, valid_n;
    logic                      uses_q, uses_n;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [DATA_WIDTH-1:0]     data_q, data_n;
    logic                      exc_q, exc_n;
    logic                      tmo_q, tmo_n;

    logic                      accept;
    logic                      src_write;
    logic [1:0]                src_size;
    logic                      src_sext;
    logic [DATA_WIDTH-1:0]     src_alu;
    logic                      src_uses;
    logic [DATA_WIDTH-1:0]     cmp_data;
    logic                      cmp_uses;

    function automatic logic [DATA_WIDTH-1:0] form_load(
        input logic [DATA_WIDTH-1:0] data,
        input logic [1:0]            size,
        input logic [LANE_WIDTH-1:0] lane,
        input logic                  sext
    );
        logic [DATA_WIDTH-1:0] sh;
        sh = data >> {lane, 3'b000};
        unique case (size)
            2'b00:   form_load = {{(DATA_WIDTH-8){sext & sh[7]}}, sh[7:0]};
            2'b01:   form_load = {{(DATA_WIDTH-16){sext & sh[15]}}, sh[15:0]};
            default: form_load = data;
        endcase
    endfunction

    function automatic logic misaligned(
        input logic [1:0]            size,
        input logic [LANE_WIDTH-1:0] lane
    );
        unique case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            default: misaligned = (lane != '0);
        endcase
    endfunction

    assign o_ready = (state_q == IDLE) || (state_q == HOLD && i_wb_ready);
    assign accept  = i_valid && o_ready;

    // A response in WAIT completes the captured request; a hit completes the live one
    assign src_write = (state_q == WAIT) ? req_write_q : i_mem_write;
    assign src_size  = (state_q == WAIT) ? req_size_q  : i_size;
    assign src_sext  = (state_q == WAIT) ? req_sext_q  : i_sign_ext;
    assign src_alu   = (state_q == WAIT) ? req_alu_q   : i_alu_result;
    assign src_uses  = (state_q == WAIT) ? req_uses_q  : i_uses_rw;

    assign cmp_uses = src_uses && !src_write;
    assign cmp_data = src_write ? src_alu :
        form_load(i_cache_data, src_size, src_alu[LANE_WIDTH-1:0], src_sext);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        req_ld  = 1'b0;
        valid_n = valid_q;
        uses_n  = uses_q;
        addr_n  = addr_q;
        data_n  = data_q;
        exc_n   = exc_q;
        tmo_n   = tmo_q;
        unique case (1'b1)
            accept: begin
                state_n = HOLD;
                valid_n = 1'b1;
                uses_n  = 1'b0;
                addr_n  = i_rw_addr;
                data_n  = i_alu_result;
                exc_n   = 1'b0;
                if (!i_is_mem_access) begin
                    uses_n = i_uses_rw;
                end else if (misaligned(i_size, i_alu_result[LANE_WIDTH-1:0])) begin
                    exc_n = 1'b1;
                end else if (i_cache_valid) begin
                    data_n = cmp_data;
                    uses_n = cmp_uses;
                end else begin
                    state_n = WAIT;
                    valid_n = 1'b0;
                    cnt_n   = '0;
                    req_ld  = 1'b1;
                end
            end
            (state_q == WAIT): begin
                addr_n = req_addr_q;
                if (i_cache_valid) begin
                    state_n = HOLD;
                    valid_n = 1'b1;
                    uses_n  = cmp_uses;
                    data_n  = cmp_data;
                    exc_n   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_n = HOLD;
                    valid_n = 1'b1;
                    uses_n  = 1'b0;
                    data_n  = '0;
                    exc_n   = 1'b1;
                    tmo_n   = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_WIDTH'(1);
                end
            end
            (state_q == HOLD && i_wb_ready && !accept): begin
                state_n = IDLE;
                valid_n = 1'b0;
                uses_n  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_write_q <= 1'b0;
            req_size_q  <= 2'b00;
            req_sext_q  <= 1'b0;
            req_alu_q   <= '0;
            req_uses_q  <= 1'b0;
            req_addr_q  <= '0;
            valid_q     <= 1'b0;
            uses_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            exc_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            if (req_ld) begin
                req_write_q <= i_mem_write;
                req_size_q  <= i_size;
                req_sext_q  <= i_sign_ext;
                req_alu_q   <= i_alu_result;
                req_uses_q  <= i_uses_rw;
                req_addr_q  <= i_rw_addr;
            end
            valid_q <= valid_n;
            uses_q  <= uses_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            exc_q   <= exc_n;
            tmo_q   <= tmo_n;
        end
    end

    assign o_wb_valid   = valid_q;
    assign o_wb_uses_rw = uses_q;
    assign o_wb_rw_addr = addr_q;
    assign o_wb_rw_data = data_q;
    assign o_wb_exc     = exc_q;
    assign o_done       = valid_q;
    assign o_timeout    = tmo_q;

endmodule

// File: tb/tb_mem_wb_stage_unit.sv
// Directed bench for mem_wb_stage_unit: single-cycle vector table plus
// hand-written WAIT, timeout, back-to-back and async-reset sequences.
module tb_mem_wb_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_is_mem_access;
    logic        i_mem_write;
    logic [1:0]  i_size;
    logic        i_sign_ext;
    logic [31:0] i_alu_result;
    logic        i_uses_rw;
    logic [4:0]  i_rw_addr;
    logic        i_cache_valid;
    logic [31:0] i_cache_data;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic        o_wb_uses_rw;
    logic [4:0]  o_wb_rw_addr;
    logic [31:0] o_wb_rw_data;
    logic        o_wb_exc;
    logic        o_done;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;

    mem_wb_stage_unit #(
        .DATA_WIDTH(32),
        .REG_ADDR_WIDTH(5),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_is_mem_access(i_is_mem_access),
        .i_mem_write(i_mem_write),
        .i_size(i_size),
        .i_sign_ext(i_sign_ext),
        .i_alu_result(i_alu_result),
        .i_uses_rw(i_uses_rw),
        .i_rw_addr(i_rw_addr),
        .i_cache_valid(i_cache_valid),
        .i_cache_data(i_cache_data),
        .o_wb_valid(o_wb_valid),
        .i_wb_ready(i_wb_ready),
        .o_wb_uses_rw(o_wb_uses_rw),
        .o_wb_rw_addr(o_wb_rw_addr),
        .o_wb_rw_data(o_wb_rw_data),
        .o_wb_exc(o_wb_exc),
        .o_done(o_done),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mem;
        logic        wr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] alu;
        logic        uses;
        logic [4:0]  rw;
        logic [31:0] cdata;
        logic [31:0] exp_data;
        logic        chk_data;
        logic        exp_uses;
        logic        exp_exc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid         = 1'b0;
        i_is_mem_access = 1'b0;
        i_mem_write     = 1'b0;
        i_size          = 2'b10;
        i_sign_ext      = 1'b0;
        i_alu_result    = 32'h0;
        i_uses_rw       = 1'b0;
        i_rw_addr       = 5'd0;
        i_cache_valid   = 1'b0;
        i_cache_data    = 32'h0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [4:0] rw);
        i_valid         = 1'b1;
        i_is_mem_access = 1'b1;
        i_mem_write     = 1'b0;
        i_size          = 2'b10;
        i_sign_ext      = 1'b0;
        i_alu_result    = addr;
        i_uses_rw       = 1'b1;
        i_rw_addr       = rw;
        i_cache_valid   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        //            mem wr size  sx alu           u  rw     cdata          exp            cd u  x
        vecs[0]  = '{1'b0,1'b0,2'b10,1'b0,32'h1234_5678,1'b1,5'd5, 32'h0,        32'h1234_5678,1'b1,1'b1,1'b0};
        vecs[1]  = '{1'b1,1'b0,2'b00,1'b1,32'h0000_0103,1'b1,5'd6, 32'h80FF_0000,32'hFFFF_FF80,1'b1,1'b1,1'b0};
        vecs[2]  = '{1'b1,1'b0,2'b00,1'b0,32'h0000_0103,1'b1,5'd6, 32'h80FF_0000,32'h0000_0080,1'b1,1'b1,1'b0};
        vecs[3]  = '{1'b1,1'b0,2'b01,1'b1,32'h0000_0102,1'b1,5'd7, 32'h80FF_0000,32'hFFFF_80FF,1'b1,1'b1,1'b0};
        vecs[4]  = '{1'b1,1'b0,2'b01,1'b0,32'h0000_0102,1'b1,5'd7, 32'h80FF_0000,32'h0000_80FF,1'b1,1'b1,1'b0};
        vecs[5]  = '{1'b1,1'b0,2'b00,1'b1,32'h0000_0101,1'b1,5'd8, 32'h1234_7F56,32'h0000_007F,1'b1,1'b1,1'b0};
        vecs[6]  = '{1'b1,1'b0,2'b01,1'b1,32'h0000_0101,1'b1,5'd9, 32'h80FF_0000,32'h0,        1'b0,1'b0,1'b1};
        vecs[7]  = '{1'b1,1'b0,2'b10,1'b0,32'h0000_0102,1'b1,5'd10,32'h80FF_0000,32'h0,        1'b0,1'b0,1'b1};
        vecs[8]  = '{1'b1,1'b1,2'b10,1'b0,32'h0000_0200,1'b1,5'd11,32'h5555_5555,32'h0000_0200,1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,2'b10,1'b0,32'hA5A5_0001,1'b0,5'd12,32'h0,        32'hA5A5_0001,1'b1,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,2'b11,1'b1,32'h0000_0010,1'b1,5'd13,32'hDEAD_BEEF,32'hDEAD_BEEF,1'b1,1'b1,1'b0};
        vecs[11] = '{1'b1,1'b0,2'b01,1'b1,32'h0000_0000,1'b1,5'd14,32'h0001_7FFF,32'h0000_7FFF,1'b1,1'b1,1'b0};

        idle_inputs();
        i_wb_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(o_wb_valid), 32'd0);
        chk("rst_uses", 32'(o_wb_uses_rw), 32'd0);
        chk("rst_addr", 32'(o_wb_rw_addr), 32'd0);
        chk("rst_data", o_wb_rw_data, 32'd0);
        chk("rst_exc", 32'(o_wb_exc), 32'd0);
        chk("rst_tmo", 32'(o_timeout), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            i_valid         = 1'b1;
            i_is_mem_access = vecs[i].mem;
            i_mem_write     = vecs[i].wr;
            i_size          = vecs[i].size;
            i_sign_ext      = vecs[i].sext;
            i_alu_result    = vecs[i].alu;
            i_uses_rw       = vecs[i].uses;
            i_rw_addr       = vecs[i].rw;
            i_cache_valid   = 1'b1;
            i_cache_data    = vecs[i].cdata;
            tick();
            idle_inputs();
            chk($sformatf("v%0d_valid", i), 32'(o_wb_valid), 32'd1);
            chk($sformatf("v%0d_done", i), 32'(o_done), 32'd1);
            chk($sformatf("v%0d_addr", i), 32'(o_wb_rw_addr), 32'(vecs[i].rw));
            chk($sformatf("v%0d_uses", i), 32'(o_wb_uses_rw), 32'(vecs[i].exp_uses));
            chk($sformatf("v%0d_exc", i), 32'(o_wb_exc), 32'(vecs[i].exp_exc));
            if (vecs[i].chk_data)
                chk($sformatf("v%0d_data", i), o_wb_rw_data, vecs[i].exp_data);
            tick();
            chk($sformatf("v%0d_drain", i), 32'(o_wb_valid), 32'd0);
            chk($sformatf("v%0d_uses0", i), 32'(o_wb_uses_rw), 32'd0);
        end

        // Word load answered in the fifth WAIT cycle, consumer stalls 3 cycles
        i_wb_ready = 1'b0;
        drive_load(32'h0000_0040, 5'd7);
        tick();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("wait%0d_valid", c), 32'(o_wb_valid), 32'd0);
            chk($sformatf("wait%0d_ready", c), 32'(o_ready), 32'd0);
            tick();
        end
        i_cache_valid = 1'b1;
        i_cache_data  = 32'hCAFE_F00D;
        tick();
        i_cache_valid = 1'b0;
        i_cache_data  = 32'h0;
        chk("wait_hold_valid", 32'(o_wb_valid), 32'd1);
        chk("wait_hold_data", o_wb_rw_data, 32'hCAFE_F00D);
        chk("wait_hold_uses", 32'(o_wb_uses_rw), 32'd1);
        chk("wait_hold_tmo", 32'(o_timeout), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d_valid", c), 32'(o_wb_valid), 32'd1);
            chk($sformatf("stall%0d_data", c), o_wb_rw_data, 32'hCAFE_F00D);
            chk($sformatf("stall%0d_addr", c), 32'(o_wb_rw_addr), 32'd7);
            chk($sformatf("stall%0d_ready", c), 32'(o_ready), 32'd0);
        end
        i_wb_ready = 1'b1;
        #1;
        chk("release_ready", 32'(o_ready), 32'd1);
        tick();
        chk("release_idle", 32'(o_wb_valid), 32'd0);

        // Response in the last WAIT cycle beats the timeout
        drive_load(32'h0000_0044, 5'd3);
        tick();
        idle_inputs();
        for (int c = 0; c < 7; c++) tick();
        chk("tie_pre_valid", 32'(o_wb_valid), 32'd0);
        i_cache_valid = 1'b1;
        i_cache_data  = 32'h0BAD_CAFE;
        tick();
        idle_inputs();
        chk("tie_valid", 32'(o_wb_valid), 32'd1);
        chk("tie_data", o_wb_rw_data, 32'h0BAD_CAFE);
        chk("tie_exc", 32'(o_wb_exc), 32'd0);
        chk("tie_tmo", 32'(o_timeout), 32'd0);
        tick();

        // No response: abort after 8 WAIT cycles
        i_wb_ready = 1'b0;
        drive_load(32'h0000_0080, 5'd9);
        tick();
        idle_inputs();
        for (int c = 0; c < 7; c++) begin
            tick();
            chk($sformatf("tmo_wait%0d", c), 32'(o_wb_valid), 32'd0);
        end
        tick();
        chk("tmo_valid", 32'(o_wb_valid), 32'd1);
        chk("tmo_uses", 32'(o_wb_uses_rw), 32'd0);
        chk("tmo_exc", 32'(o_wb_exc), 32'd1);
        chk("tmo_data", o_wb_rw_data, 32'd0);
        chk("tmo_flag", 32'(o_timeout), 32'd1);

        // Back-to-back ALU ops straight out of HOLD, one per cycle
        i_wb_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            v = 32'h1111_1111 * (k + 1);
            i_valid      = 1'b1;
            i_alu_result = v;
            i_uses_rw    = 1'b1;
            i_rw_addr    = 5'(k + 20);
            tick();
            chk($sformatf("b2b%0d_valid", k), 32'(o_wb_valid), 32'd1);
            chk($sformatf("b2b%0d_data", k), o_wb_rw_data, v);
            chk($sformatf("b2b%0d_addr", k), 32'(o_wb_rw_addr), 32'(k + 20));
            chk($sformatf("b2b%0d_exc", k), 32'(o_wb_exc), 32'd0);
            chk($sformatf("b2b%0d_tmo", k), 32'(o_timeout), 32'd1);
        end
        idle_inputs();
        tick();
        chk("b2b_drain", 32'(o_wb_valid), 32'd0);

        // Async reset in the middle of a WAIT
        drive_load(32'h0000_00C0, 5'd4);
        tick();
        idle_inputs();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(o_wb_valid), 32'd0);
        chk("arst_tmo", 32'(o_timeout), 32'd0);
        chk("arst_data", o_wb_rw_data, 32'd0);
        chk("arst_addr", 32'(o_wb_rw_addr), 32'd0);
        chk("arst_ready", 32'(o_ready), 32'd1);
        #1;
        rst = 1'b0;
        i_cache_valid = 1'b1;
        i_cache_data  = 32'h7777_7777;
        tick();
        chk("late_resp_valid", 32'(o_wb_valid), 32'd0);
        chk("late_resp_uses", 32'(o_wb_uses_rw), 32'd0);
        tick();
        chk("late_resp_valid2", 32'(o_wb_valid), 32'd0);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage_unit.md
Name: mem_wb_stage_unit

Overview:
Parametrised successor to the combinational memory-stage glue. Sits between the MEM stage and the register-file write-back. It accepts one EX-stage result per handshake and waits (multi-cycle) for the D-cache response on memory accesses. It aligns and extends sub-word loads, flags misaligned accesses, and bounds cache waits with a timeout. The write-back result is held in an output register until the consumer accepts it.

Parameters:
DATA_WIDTH, 32, datapath width in bits; multiple of 16, ≥32.
REG_ADDR_WIDTH, 5, register-file address width.
TIMEOUT_CYCLES, 255, maximum WAIT cycles before abort; ≥1.
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), derived timeout-counter width; not overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous and active-high.
i_valid  input  1  EX result present this cycle.
o_ready  output  1  unit can accept i_valid this cycle.
i_is_mem_access  input  1  the instruction accesses memory.
i_mem_write  input  1  1 = store, 0 = load; ignored when not a memory access.
i_size  input  2  00 byte, 01 half, 10 full word, 11 treated as full word.
i_sign_ext  input  1  sign-extend sub-word loads.
i_alu_result  input  DATA_WIDTH  ALU result or effective address.
i_uses_rw  input  1  instruction writes a register.
i_rw_addr  input  REG_ADDR_WIDTH  destination register.
i_cache_valid  input  1  D-cache response valid.
i_cache_data  input  DATA_WIDTH  D-cache read data, little-endian lanes.
o_wb_valid  output  1  write-back register holds a result.
i_wb_ready  input  1  consumer accepts the result.
o_wb_uses_rw  output  1  write-back enable.
o_wb_rw_addr  output  REG_ADDR_WIDTH  write-back destination.
o_wb_rw_data  output  DATA_WIDTH  write-back data.
o_wb_exc  output  1  result carries a misalign or timeout exception.
o_done  output  1  equals o_wb_valid; drives the hazard controller.
o_timeout  output  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, any state, including mid-WAIT):
  - state = IDLE; counter = 0.
  - o_wb_valid, o_wb_uses_rw, o_wb_exc, o_timeout = 0.
  - o_wb_rw_addr, o_wb_rw_data = 0.
  - o_ready = 1 combinationally after reset.
- States: IDLE, WAIT, HOLD.
- o_ready = (state == IDLE) or (state == HOLD and i_wb_ready). This allows back-to-back transfer with zero bubbles.
- Accept = i_valid and o_ready. All request fields are captured on accept. i_valid without o_ready is ignored, and upstream must hold it.
- Lane index L = address low bits, $clog2(DATA_WIDTH/8) wide.
- Misaligned cases:
  - half access with L[0] = 1;
  - full-word access with L ≠ 0.
- Accepting a non-memory instruction: go to HOLD next cycle.
  - o_wb_rw_data = i_alu_result; o_wb_uses_rw = i_uses_rw; o_wb_exc = 0.
  - Latency is 1 cycle.
- Accepting a misaligned memory access: go to HOLD next cycle with uses_rw = 0 and exc = 1. The cache response is not waited for.
- Accepting an aligned memory access:
  - If i_cache_valid is high in the accept cycle (hit), go to HOLD next cycle.
  - Otherwise go to WAIT with counter = 0.
- WAIT:
  - Counter increments each cycle.
  - If i_cache_valid is high: go to HOLD and capture the data.
  - Else if counter == TIMEOUT_CYCLES−1: go to HOLD with uses_rw = 0, data = 0, exc = 1, and set o_timeout.
  - If the response arrives in the same cycle the limit is reached, the response wins and there is no timeout.
  - i_cache_valid in IDLE or HOLD is ignored.
- Load data formation (captured in the cycle the response is accepted):
  - byte: byte lane L of i_cache_data.
  - half: 16 bits starting at byte L.
  - Both are zero-extended, or sign-extended when i_sign_ext = 1.
  - full word: i_cache_data unchanged.
  - o_wb_uses_rw = i_uses_rw.
- Store completion: uses_rw = 0, exc = 0, data = i_alu_result.
- HOLD:
  - o_wb_valid = 1 and all wb outputs are stable.
  - On i_wb_ready with a new accept: load the next result directly, following the accept rules above.
  - On i_wb_ready without accept: go to IDLE and clear o_wb_valid.
  - Without i_wb_ready: hold.
- o_timeout stays 1 until reset.
- o_wb_uses_rw is never 1 when o_wb_valid = 0.

Test Plan:
- Reset, then accept ALU op (result 0x1234_5678, rw 5, uses_rw 1) with i_wb_ready = 1 → next cycle o_wb_valid = 1, rw_addr = 5, data = 0x12345678; the cycle after that, o_wb_valid = 0.
- Signed byte load, addr 0x…3, cache hit in the accept cycle with data 0x80FF_0000 → data = 0xFFFF_FF80. Repeat unsigned → 0x0000_0080. Half load at addr 0x…2 signed → 0xFFFF_80FF.
- Word load, cache responds after 4 WAIT cycles → o_wb_valid 5 cycles after accept, correct data, o_timeout = 0. Keep i_wb_ready = 0 for 3 cycles → outputs stable and o_ready = 0.
- Word load with no response, TIMEOUT_CYCLES = 8 → HOLD after 8 WAIT cycles with uses_rw = 0, exc = 1, o_timeout = 1; o_timeout stays 1 through later transactions until rst.
- Half load at addr 0x…1 → next cycle exc = 1, uses_rw = 0, no WAIT. Then back-to-back ALU ops with i_valid and i_wb_ready held high → one result per cycle, no bubbles.
- Assert rst asynchronously mid-WAIT → all outputs 0 immediately and state IDLE; a late i_cache_valid after reset produces no write-back.
